silly_stim_sequencer: RTL and testbench
=======================================

// Module: silly_stim_sequencer
// PURPOSE
//  Input-side controller for the silly1 core: decides what drives the core's 8-bit input each cycle.
//  Modes: pass ui_in straight through, or load a short byte pattern from the bidirectional pins and replay it.
//  Replay runs once or loops, at a programmable rate.
//  Sits between the top-level pins (ui_in/uio_in) and silly1.ui_in; the core output path is untouched.
// PARAMETERS
//  DEPTH   8   pattern memory entries (power of 2, >=2)
//  DW      8   data width; matches core input
//  RATE_W  4   width of rate_sel; step period = 2**rate_sel clocks
// PORTS
//  clk       in   1       core clock
//  rst_n     in   1       asynchronous, active-low reset
//  ui_in     in   DW      pass-through source (PASS mode)
//  cfg_data  in   DW      pattern byte to load (from uio_in)
//  cfg_wr    in   1       write strobe pin, asynchronous; rising edge = one write
//  cfg_mode  in   2       asynchronous pin; 00 PASS, 01 LOAD, 10 PLAY_ONCE, 11 PLAY_LOOP
//  rate_sel  in   RATE_W  replay step period exponent; sampled when entering PLAY and at each step
//  core_in   out  DW      registered drive to silly1.ui_in
//  busy      out  1       high while in PLAY
//  idx       out  clog2(DEPTH)  current replay index
//  ovf       out  1       sticky: write attempted with pattern memory full
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=PASS, core_in=0, busy=0, idx=0, ovf=0, wr_ptr=0, len=0, tick=0, memory cleared to 0.
//  - cfg_wr and cfg_mode pass through 2-flop synchronisers.
//  - cfg_wr rising edge is detected on the synchronised signal.
//  - Pin edge to memory write = 3 clocks; mode pin change to state change = 3 clocks.
//  - cfg_data is sampled on the write-enable cycle; it must be held stable >=3 clocks after the cfg_wr rise.
//  - FSM states: PASS, LOAD, PLAY, DONE. Mode is the synchronised cfg_mode. Evaluated every cycle.
//  - PASS: core_in <= ui_in (1-clock latency).
//    - mode 01 -> LOAD; clears wr_ptr, len and ovf.
//    - mode 1x -> PLAY (rd_ptr=0, tick=0).
//  - LOAD: core_in holds its last value.
//    - Each wr edge with len<DEPTH: mem[wr_ptr]<=cfg_data; wr_ptr++; len++.
//    - Wr edge with len==DEPTH: write dropped, ovf<=1.
//    - mode 00 -> PASS; mode 1x -> PLAY.
//  - PLAY (busy=1): core_in <= mem[idx] every cycle.
//    - tick counts 0..2**rate_sel-1. At the terminal count, tick<=0 and the step resolves as follows.
//    - idx<len-1: idx++.
//    - idx==len-1 in mode 11: idx<=0 (wrap).
//    - idx==len-1 in mode 10: go to DONE with idx held.
//    - rate_sel=0 means one step per clock.
//  - PLAY with len==0: go directly to DONE with core_in<=0.
//  - DONE (busy=0): core_in holds the last replayed byte.
//    - mode 00 -> PASS; mode 01 -> LOAD.
//    - mode 1x re-entered from 00/01 only; no auto-restart while mode stays 1x.
//  - Mode changes mid-PLAY:
//    - 00 -> PASS next cycle (tick and idx cleared).
//    - 01 -> LOAD (pattern cleared).
//    - 10<->11 toggle: no state change; only the end-of-pattern decision uses the new value.
//  - Wr edges outside LOAD are ignored; ovf is unaffected.
//  - Reset mid-operation aborts immediately and discards pattern contents. Outputs take reset values asynchronously.
//  - Widths: wr_ptr/idx = clog2(DEPTH); len = clog2(DEPTH)+1; tick = 2**RATE_W-1 max range, no overflow.
// STRUCTURE
//  - Package silly_pkg holds the state enum (PASS/LOAD/PLAY/DONE) and the mode constants:
//    MODE_PASS=2'b00, MODE_LOAD=2'b01, MODE_ONCE=2'b10, MODE_LOOP=2'b11.
//  - One sub-module silly_sync (parameterised-width 2-flop synchroniser, async active-low reset), used for cfg_wr and cfg_mode.
//  - Memory is a flop array in this module. The top wires core_in to silly1.ui_in.
// TESTING
//  1. Reset with ui_in=0xA5 held, then mode 00 -> core_in=0x00 during reset; core_in=0xA5 one clock after first clock edge post-reset.
//  2. LOAD 0x11,0x22,0x33, mode 11, rate_sel=0 -> core_in cycles 11,22,33,11,... one step per clk; busy=1; idx 0,1,2,0.
//  3. Same pattern, mode 10, rate_sel=2 -> each byte held 4 clks; after 0x33, state DONE, core_in stays 0x33, busy=0.
//  4. 9 wr edges with DEPTH=8 -> ovf=1 and len=8; 9th byte absent from replay; re-entering LOAD clears ovf.
//  5. Mode 11 -> 00 mid-replay -> core_in tracks ui_in within 4 clks of the pin change, idx=0, busy=0.
//  6. PLAY with empty pattern (LOAD then immediately 10) -> DONE, core_in=0x00, busy never asserts beyond 1 clk.

Source files
------------

// File: rtl/silly_pkg.sv
// Shared types for the silly1 input-side stimulus sequencer.
package silly_pkg;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;
  localparam logic [1:0] MODE_LOOP = 2'b11;

endpackage

// File: rtl/silly_sync.sv
// Two-flop synchroniser for asynchronous pins, parameterised width.
module silly_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/silly_stim_sequencer.sv
// Chooses what drives silly1.ui_in: live pins, or a short pattern loaded from uio_in and replayed.
//
// state | meaning
// PASS  | core_in follows ui_in with one clock of latency
// LOAD  | capture cfg_data on each synchronised cfg_wr rise; core_in holds
// PLAY  | replay mem[0..len-1] at 2**rate_sel clocks per step; busy high
// DONE  | single replay finished; core_in holds last byte until mode leaves 1x
module silly_stim_sequencer
  import silly_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DW     = 8,
  parameter int RATE_W = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int LW    = IW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DW-1:0]     i_ui_in,
  input  logic [DW-1:0]     i_cfg_data,
  input  logic              i_cfg_wr,
  input  logic [1:0]        i_cfg_mode,
  input  logic [RATE_W-1:0] i_rate_sel,
  output logic [DW-1:0]     o_core_in,
  output logic              o_busy,
  output logic [IW-1:0]     o_idx,
  output logic              o_ovf
);

  localparam int TW = (2 ** RATE_W) - 1;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_core_in, w_core_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [IW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [LW-1:0]   r_len, w_len_nxt;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_wr_d;
  logic            w_mem_we;
  logic            w_wr_s;
  logic            w_wr_rise;
  logic [1:0]      w_mode;
  logic [TW-1:0]   w_tick_load;
  logic            w_last;
  logic [DW-1:0]   r_mem [DEPTH];

  silly_sync #(.W(1)) u_sync_wr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_cfg_wr),
    .o_q     (w_wr_s)
  );

  silly_sync #(.W(2)) u_sync_mode (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_cfg_mode),
    .o_q     (w_mode)
  );

  assign w_wr_rise = w_wr_s & ~r_wr_d;

  // Step timer is a down-counter reloaded with the period on PLAY entry and at every step,
  // so rate_sel takes effect exactly at those points; the shift wraps cleanly at the max rate.
  assign w_tick_load = (TW'(1) << i_rate_sel) - TW'(1);
  assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_core_nxt   = r_core_in;
    w_idx_nxt    = r_idx;
    w_wr_ptr_nxt = r_wr_ptr;
    w_len_nxt    = r_len;
    w_tick_nxt   = r_tick;
    w_ovf_nxt    = r_ovf;
    w_mem_we     = 1'b0;

    unique case (r_state)
      ST_PASS: begin
        w_core_nxt = i_ui_in;
        if (w_mode == MODE_LOAD) begin
          w_state_nxt  = ST_LOAD;
          w_wr_ptr_nxt = '0;
          w_len_nxt    = '0;
          w_ovf_nxt    = 1'b0;
        end else if (w_mode[1]) begin
          w_state_nxt = ST_PLAY;
          w_idx_nxt   = '0;
          w_tick_nxt  = w_tick_load;
        end
      end

      ST_LOAD: begin
        if (w_wr_rise) begin
          if (r_len == LW'(DEPTH)) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + IW'(1);
            w_len_nxt    = r_len + LW'(1);
          end
        end
        if (w_mode == MODE_PASS) begin
          w_state_nxt = ST_PASS;
          w_idx_nxt   = '0;
        end else if (w_mode[1]) begin
          w_state_nxt = ST_PLAY;
          w_idx_nxt   = '0;
          w_tick_nxt  = w_tick_load;
        end
      end

      ST_PLAY: begin
        w_core_nxt = (r_len == '0) ? '0 : r_mem[r_idx];
        if (w_mode == MODE_PASS) begin
          w_state_nxt = ST_PASS;
          w_idx_nxt   = '0;
          w_tick_nxt  = '0;
        end else if (w_mode == MODE_LOAD) begin
          w_state_nxt  = ST_LOAD;
          w_idx_nxt    = '0;
          w_tick_nxt   = '0;
          w_wr_ptr_nxt = '0;
          w_len_nxt    = '0;
          w_ovf_nxt    = 1'b0;
        end else if (r_len == '0) begin
          w_state_nxt = ST_DONE;
          w_tick_nxt  = '0;
        end else if (r_tick == '0) begin
          w_tick_nxt = w_tick_load;
          if (!w_last) begin
            w_idx_nxt = r_idx + IW'(1);
          end else if (w_mode == MODE_LOOP) begin
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = ST_DONE;
            w_tick_nxt  = '0;
          end
        end else begin
          w_tick_nxt = r_tick - TW'(1);
        end
      end

      ST_DONE: begin
        if (w_mode == MODE_PASS) begin
          w_state_nxt = ST_PASS;
          w_idx_nxt   = '0;
        end else if (w_mode == MODE_LOAD) begin
          w_state_nxt  = ST_LOAD;
          w_idx_nxt    = '0;
          w_wr_ptr_nxt = '0;
          w_len_nxt    = '0;
          w_ovf_nxt    = 1'b0;
        end
      end

      default: w_state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_core_in <= '0;
      r_idx     <= '0;
      r_wr_ptr  <= '0;
      r_len     <= '0;
      r_tick    <= '0;
      r_ovf     <= 1'b0;
      r_wr_d    <= 1'b0;
    end else begin
      r_core_in <= w_core_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_len     <= w_len_nxt;
      r_tick    <= w_tick_nxt;
      r_ovf     <= w_ovf_nxt;
      r_wr_d    <= w_wr_s;
    end
  end

  // cfg_data is taken straight from the pin; the writer holds it across the synchroniser delay.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[r_wr_ptr] <= i_cfg_data;
    end
  end

  assign o_core_in = r_core_in;
  assign o_busy    = (r_state == ST_PLAY);
  assign o_idx     = r_idx;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_silly_stim_sequencer.sv
// Directed bench for silly_stim_sequencer: pass-through, load, loop/once replay, overflow, aborts.
module tb_silly_stim_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] cfg_data;
  logic       cfg_wr;
  logic [1:0] cfg_mode;
  logic [3:0] rate_sel;
  logic [7:0] core_in;
  logic       busy;
  logic [2:0] idx;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  silly_stim_sequencer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ui_in    (ui_in),
    .i_cfg_data (cfg_data),
    .i_cfg_wr   (cfg_wr),
    .i_cfg_mode (cfg_mode),
    .i_rate_sel (rate_sel),
    .o_core_in  (core_in),
    .o_busy     (busy),
    .o_idx      (idx),
    .o_ovf      (ovf)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cfg_mode = m;
    step(3);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    cfg_data = b;
    cfg_wr   = 1'b1;
    step(3);
    cfg_wr   = 1'b0;
    step(3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ui_in = 8'hA5; cfg_mode = 2'b00; cfg_wr = 1'b0;
    cfg_data = 8'h00; rate_sel = 4'd0;
    #22;
    n_cmp++; if (core_in !== 8'h00) begin n_err++; $display("FAIL reset_core got %h want 00", core_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", idx); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    @(posedge clk); #1; rst_n = 1'b1;
    step(1);
    n_cmp++; if (core_in !== 8'hA5) begin n_err++; $display("FAIL pass_first got %h want a5", core_in); end
    step(1);
    n_cmp++; if (core_in !== 8'hA5) begin n_err++; $display("FAIL pass_second got %h want a5", core_in); end
  endtask

  task automatic test_loop;
    logic [7:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    set_mode(2'b01);
    for (int i = 0; i < 3; i++) wr_byte(pat[i]);
    rate_sel = 4'd0;
    set_mode(2'b11);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL loop_entry_busy got %b want 1", busy); end
    n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL loop_entry_idx got %0d want 0", idx); end
    for (int k = 0; k < 6; k++) begin
      step(1);
      n_cmp++; if (core_in !== pat[k % 3]) begin n_err++; $display("FAIL loop_core[%0d] got %h want %h", k, core_in, pat[k % 3]); end
      n_cmp++; if (idx !== 3'((k + 1) % 3)) begin n_err++; $display("FAIL loop_idx[%0d] got %0d want %0d", k, idx, (k + 1) % 3); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL loop_busy[%0d] got %b want 1", k, busy); end
    end
  endtask

  task automatic test_once;
    logic [7:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    set_mode(2'b00);
    rate_sel = 4'd2;
    set_mode(2'b10);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL once_entry_busy got %b want 1", busy); end
    for (int k = 0; k < 12; k++) begin
      step(1);
      n_cmp++; if (core_in !== pat[k / 4]) begin n_err++; $display("FAIL once_core[%0d] got %h want %h", k, core_in, pat[k / 4]); end
      n_cmp++; if (busy !== (k < 11)) begin n_err++; $display("FAIL once_busy[%0d] got %b want %b", k, busy, k < 11); end
    end
    ui_in = 8'h77;
    for (int k = 0; k < 5; k++) begin
      step(1);
      n_cmp++; if (core_in !== 8'h33) begin n_err++; $display("FAIL done_hold[%0d] got %h want 33", k, core_in); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy[%0d] got %b want 0", k, busy); end
      n_cmp++; if (idx !== 3'd2) begin n_err++; $display("FAIL done_idx[%0d] got %0d want 2", k, idx); end
    end
  endtask

  task automatic test_overflow;
    set_mode(2'b00);
    set_mode(2'b01);
    for (int i = 0; i < 9; i++) begin
      wr_byte(8'h81 + 8'(i));
      if (i == 7) begin
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got %b want 0", ovf); end
      end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_ninth got %b want 1", ovf); end
    rate_sel = 4'd0;
    set_mode(2'b10);
    for (int k = 0; k < 8; k++) begin
      step(1);
      n_cmp++; if (core_in !== 8'h81 + 8'(k)) begin n_err++; $display("FAIL full_core[%0d] got %h want %h", k, core_in, 8'h81 + 8'(k)); end
      n_cmp++; if (busy !== (k < 7)) begin n_err++; $display("FAIL full_busy[%0d] got %b want %b", k, busy, k < 7); end
    end
    step(2);
    n_cmp++; if (core_in !== 8'h88) begin n_err++; $display("FAIL no_ninth got %h want 88", core_in); end
    wr_byte(8'h99);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL wr_outside_load_ovf got %b want 1", ovf); end
    n_cmp++; if (core_in !== 8'h88) begin n_err++; $display("FAIL wr_outside_load_core got %h want 88", core_in); end
    set_mode(2'b01);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf); end
  endtask

  task automatic test_abort_to_pass;
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    rate_sel = 4'd1;
    set_mode(2'b11);
    step(5);
    ui_in    = 8'h5C;
    cfg_mode = 2'b00;
    step(4);
    n_cmp++; if (core_in !== 8'h5C) begin n_err++; $display("FAIL abort_core got %h want 5c", core_in); end
    n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL abort_idx got %0d want 0", idx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    ui_in = 8'h3E;
    step(1);
    n_cmp++; if (core_in !== 8'h3E) begin n_err++; $display("FAIL pass_track got %h want 3e", core_in); end
  endtask

  task automatic test_empty;
    int busy_cnt;
    busy_cnt = 0;
    set_mode(2'b01);
    cfg_mode = 2'b10;
    step(3);
    for (int k = 0; k < 6; k++) begin
      if (busy === 1'b1) busy_cnt++;
      step(1);
    end
    n_cmp++; if (busy_cnt > 1) begin n_err++; $display("FAIL empty_busy_cycles got %0d want <=1", busy_cnt); end
    n_cmp++; if (core_in !== 8'h00) begin n_err++; $display("FAIL empty_core got %h want 00", core_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy_end got %b want 0", busy); end
  endtask

  task automatic test_async_reset;
    set_mode(2'b00);
    set_mode(2'b01);
    wr_byte(8'hC1); wr_byte(8'hC2); wr_byte(8'hC3);
    rate_sel = 4'd0;
    set_mode(2'b11);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (core_in !== 8'h00) begin n_err++; $display("FAIL async_core got %h want 00", core_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b want 0", busy); end
    n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL async_idx got %0d want 0", idx); end
    step(2);
    rst_n = 1'b1;
    step(8);
    n_cmp++; if (core_in !== 8'h00) begin n_err++; $display("FAIL discard_core got %h want 00", core_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL discard_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_once();
    test_overflow();
    test_abort_to_pass();
    test_empty();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
